// File: rtl/wishbone_arbiter_interconnect_if.sv
// Wishbone classic bus bundle. The master modport drives the request side.
// The slave modport drives the response side.
`timescale 1ns/1ps
interface wishbone_interface;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat_mosi;
    logic [31:0] dat_miso;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, adr, sel, we, dat_mosi,
                    input  dat_miso, ack, err);
    modport slave  (input  cyc, stb, adr, sel, we, dat_mosi,
                    output dat_miso, ack, err);
endinterface

// File: rtl/wishbone_arbiter_interconnect.sv
// Shared-bus Wishbone interconnect. It arbitrates round-robin among masters,
// locks the grant for a whole cyc, decodes to address-mapped slaves and enforces a bus timeout.
//
// state | meaning
// IDLE  | no owner; pick the next requester after last_owner
// OWNED | owner_q holds the bus until its cyc is sampled low
`timescale 1ns/1ps
module wishbone_arbiter_interconnect #(
    parameter int                     NUM_MASTERS    = 2,
    parameter int                     NUM_SLAVES     = 4,
    parameter bit [32*NUM_SLAVES-1:0] SLAVE_ADDRESS  = {32'h0000_3000, 32'h0000_2000,
                                                        32'h0000_1000, 32'h0000_0000},
    parameter bit [32*NUM_SLAVES-1:0] SLAVE_SIZE     = {4{32'h0000_1000}},
    parameter int                     TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wishbone_interface.slave       masters [NUM_MASTERS],
    wishbone_interface.master      slaves  [NUM_SLAVES],
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   decode_err_o,
    output logic                   timeout_o
);
    localparam int OWNER_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [OWNER_W-1:0] owner_q, owner_d, last_q, last_d, winner;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               found_w;
    int                 idx;

    logic [NUM_MASTERS-1:0] m_cyc, m_stb, m_we;
    logic [31:0]            m_adr [NUM_MASTERS];
    logic [31:0]            m_dat [NUM_MASTERS];
    logic [3:0]             m_sel [NUM_MASTERS];

    logic        owned, own_cyc, own_stb, own_we, req;
    logic [31:0] own_adr, own_dat;
    logic [3:0]  own_sel;

    logic [NUM_SLAVES-1:0] match, sel_hit, s_ack, s_err;
    logic [31:0]           s_dat   [NUM_SLAVES];
    logic [31:0]           dat_acc [NUM_SLAVES+1];
    logic [31:0]           dat_m;
    logic                  ack_sel, err_sel, decode_err, timeout_hit, ack_m, err_m;

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_master
        assign m_cyc[k]            = masters[k].cyc;
        assign m_stb[k]            = masters[k].stb;
        assign m_we[k]             = masters[k].we;
        assign m_adr[k]            = masters[k].adr;
        assign m_dat[k]            = masters[k].dat_mosi;
        assign m_sel[k]            = masters[k].sel;
        assign masters[k].ack      = ack_m & grant_o[k];
        assign masters[k].err      = err_m & grant_o[k];
        assign masters[k].dat_miso = grant_o[k] ? dat_m : 32'h0;
    end

    assign owned   = (state_q == OWNED);
    assign own_cyc = owned & m_cyc[owner_q];
    assign own_stb = owned & m_stb[owner_q];
    assign own_we  = owned & m_we[owner_q];
    assign own_adr = owned ? m_adr[owner_q] : 32'h0;
    assign own_dat = owned ? m_dat[owner_q] : 32'h0;
    assign own_sel = owned ? m_sel[owner_q] : 4'h0;
    assign req     = own_cyc & own_stb;

    // 33-bit subtractions: the borrow bit gives adr < base and offset < size without wrap at 2^32
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
        localparam logic [32:0] BASE = {1'b0, SLAVE_ADDRESS[32*i +: 32]};
        localparam logic [32:0] SIZE = {1'b0, SLAVE_SIZE[32*i +: 32]};
        logic [32:0] offset, beyond;

        assign offset   = {1'b0, own_adr} - BASE;
        assign beyond   = {1'b0, offset[31:0]} - SIZE;
        assign match[i] = ~offset[32] & beyond[32];

        assign slaves[i].cyc      = own_cyc;
        assign slaves[i].stb      = sel_hit[i];
        assign slaves[i].adr      = own_adr;
        assign slaves[i].sel      = own_sel;
        assign slaves[i].we       = own_we;
        assign slaves[i].dat_mosi = own_dat;

        assign s_ack[i]     = slaves[i].ack;
        assign s_err[i]     = slaves[i].err;
        assign s_dat[i]     = slaves[i].dat_miso;
        assign dat_acc[i+1] = dat_acc[i] | (sel_hit[i] ? s_dat[i] : 32'h0);
    end
    assign dat_acc[0] = 32'h0;
    assign dat_m      = dat_acc[NUM_SLAVES];

    // Lowest matching index wins on overlap: isolate the least significant set bit
    assign sel_hit     = req ? (match & ((~match) + NUM_SLAVES'(1))) : '0;
    assign ack_sel     = |(sel_hit & s_ack);
    assign err_sel     = |(sel_hit & s_err);
    assign decode_err  = req & ~(|match);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && req && (cnt_q == CNT_LIMIT);

    assign ack_m        = ack_sel;
    assign err_m        = ~ack_sel & (err_sel | decode_err | timeout_hit);
    assign decode_err_o = decode_err;
    assign timeout_o    = timeout_hit & ~ack_sel;

    always_comb begin
        winner  = '0;
        found_w = 1'b0;
        idx     = 0;
        for (int j = 1; j <= NUM_MASTERS; j++) begin
            idx = (int'(last_q) + j) % NUM_MASTERS;
            if (!found_w && m_cyc[idx[OWNER_W-1:0]]) begin
                found_w = 1'b1;
                winner  = idx[OWNER_W-1:0];
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        if ((TIMEOUT_CYCLES != 0) && req && !ack_m && !err_m) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found_w) begin
                    state_d = OWNED;
                    owner_d = winner;
                end
            end
            OWNED: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_o = '0;
        if (owned) begin
            grant_o[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OWNER_W'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
